// File: rtl/pfa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package pfa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pfa_gp_t;

    function automatic int unsigned pfa_levels(input int unsigned width);
        return $clog2(width);
    endfunction

    // Rounded (half up) position of internal bank j in the LEVELS+1 step chain.
    function automatic int unsigned pfa_cut(input int unsigned j, input int unsigned stages,
                                            input int unsigned levels);
        return (2 * j * (levels + 1) + stages) / (2 * stages);
    endfunction

    function automatic bit pfa_is_cut(input int unsigned t, input int unsigned stages,
                                      input int unsigned levels);
        bit hit;
        hit = 1'b0;
        for (int unsigned j = 1; j < stages; j++) begin
            if (pfa_cut(j, stages, levels) == t) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pfa_prefix_cell.sv
// Kogge-Stone black cell: merges a high group (gh,ph) with the adjacent low group (gl,pl).
module pfa_prefix_cell
    import pfa_pkg::*;
(
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    pfa_gp_t res;

    assign res.g = gh | (ph & gl);
    assign res.p = ph & pl;
    assign g     = res.g;
    assign p     = res.p;

endmodule

// File: rtl/pfa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and global stall.
// Define PFA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module pfa_pipe
    import pfa_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PFA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned LEVELS = pfa_levels(WIDTH);

    // Index t holds values after step t: step 0 is the p/g pre-step, steps 1..LEVELS the tree.
    logic [LEVELS:0][WIDTH-1:0] g_o, p_o, pp_o;
    logic [LEVELS:0][WIDTH-1:0] g_i, p_i, pp_i;
    logic [LEVELS:0]            c0_o, c0_i, v_o, v_i;

    logic             stall;
    logic [WIDTH-1:0] y_adj;
    logic             cin_adj;
    logic [WIDTH-1:0] carry;
    logic             cout_c;
    logic             unused_p;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Carry-in is folded into bit 0's generate so the tree yields true carries directly.
    assign y_adj    = sub ? ~y : y;
    assign cin_adj  = sub | cin;
    assign pp_o[0]  = x ^ y_adj;
    assign p_o[0]   = pp_o[0];
    assign g_o[0]   = {x[WIDTH-1:1] & y_adj[WIDTH-1:1],
                       (x[0] & y_adj[0]) | (pp_o[0][0] & cin_adj)};
    assign c0_o[0]  = cin_adj;
    assign v_o[0]   = in_valid & in_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                pfa_prefix_cell u_cell (
                    .gh (g_i[k][i]),
                    .ph (p_i[k][i]),
                    .gl (g_i[k][i-D]),
                    .pl (p_i[k][i-D]),
                    .g  (g_o[k+1][i]),
                    .p  (p_o[k+1][i])
                );
            end else begin : g_pass
                assign g_o[k+1][i] = g_i[k][i];
                assign p_o[k+1][i] = p_i[k][i];
            end
        end
        assign pp_o[k+1] = pp_i[k];
        assign c0_o[k+1] = c0_i[k];
        assign v_o[k+1]  = v_i[k];
    end

    // Internal banks sit after the selected steps; elsewhere the step output feeds straight on.
    for (genvar t = 0; t <= LEVELS; t++) begin : g_stage
        if (pfa_is_cut(t, STAGES, LEVELS)) begin : g_bank
            logic [WIDTH-1:0] g_q, p_q, pp_q;
            logic             c0_q, v_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    pp_q <= '0;
                    c0_q <= 1'b0;
                    v_q  <= 1'b0;
                end else if (!stall) begin
                    g_q  <= g_o[t];
                    p_q  <= p_o[t];
                    pp_q <= pp_o[t];
                    c0_q <= c0_o[t];
                    v_q  <= v_o[t];
                end
            end
            assign g_i[t]  = g_q;
            assign p_i[t]  = p_q;
            assign pp_i[t] = pp_q;
            assign c0_i[t] = c0_q;
            assign v_i[t]  = v_q;
        end else begin : g_wire
            assign g_i[t]  = g_o[t];
            assign p_i[t]  = p_o[t];
            assign pp_i[t] = pp_o[t];
            assign c0_i[t] = c0_o[t];
            assign v_i[t]  = v_o[t];
        end
    end

    // Group propagate of the full tree is never needed.
    assign unused_p = ^p_i[LEVELS];

    assign carry  = {g_i[LEVELS][WIDTH-2:0], c0_i[LEVELS]};
    assign cout_c = g_i[LEVELS][WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef PFA_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid <= v_i[LEVELS];
            s         <= pp_i[LEVELS] ^ carry;
            cout      <= cout_c;
`ifdef PFA_PIPE_OVF_EN
            ovf       <= carry[WIDTH-1] ^ cout_c;
`endif
        end
    end

endmodule

// File: tb/tb_pfa_pipe.sv
// Self-checking bench: six pfa_pipe configurations share one stimulus stream, each scored
// against an arithmetic model queue; directed vectors carry hand-computed literal results.
`timescale 1ns/1ps
module tb_pfa_pipe;

    localparam int ND = 6;
    localparam int unsigned WS [ND] = '{16, 32, 8, 13, 64, 2};
    localparam int unsigned ST [ND] = '{1, 3, 4, 2, 7, 2};
    localparam int QD = 64;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        lit;
        logic [63:0] ls;
        logic        lc;
        logic        lo;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] x = '0;
    logic [63:0] y = '0;

    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic        cout_a    [ND];
    logic        ovf_a     [ND];
    logic [63:0] s_a       [ND];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int unsigned W = WS[d];
        logic [W-1:0] s_w;
        pfa_pipe #(.WIDTH(W), .STAGES(ST[d])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[d]),
            .x         (x[W-1:0]),
            .y         (y[W-1:0]),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid[d]),
            .out_ready (out_ready),
            .s         (s_w),
            .cout      (cout_a[d])
`ifdef PFA_PIPE_OVF_EN
            ,
            .ovf       (ovf_a[d])
`endif
        );
        assign s_a[d] = 64'(s_w);
`ifndef PFA_PIPE_OVF_EN
        assign ovf_a[d] = 1'b0;
`endif
    end

    // Reference: plain wide addition, with overflow from operand/result sign bits.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb);
        logic [64:0] mask, am, bm, sum;
        exp_t e;
        mask  = (65'd1 << w) - 65'd1;
        am    = {1'b0, a} & mask;
        bm    = {1'b0, sb ? ~b : b} & mask;
        sum   = am + bm + 65'(ci | sb);
        e     = '0;
        e.s   = 64'(sum & mask);
        e.c   = sum[w];
        e.o   = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
        return e;
    endfunction

    int unsigned cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic        rst_seen = 1'b0;
    logic        final_chk = 1'b0;
    logic        prev_stall [ND];
    logic [63:0] prev_s     [ND];
    logic        prev_c     [ND];
    logic        prev_o     [ND];
    logic        lit_en     [ND];
    logic [63:0] lit_s      [ND];
    logic        lit_c      [ND];
    logic        lit_o      [ND];
    exp_t        qbuf       [ND][QD];
    int unsigned head       [ND];
    int unsigned tail       [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            prev_stall[d] = 1'b0; prev_s[d] = '0; prev_c[d] = 1'b0; prev_o[d] = 1'b0;
            lit_en[d] = 1'b0; lit_s[d] = '0; lit_c[d] = 1'b0; lit_o[d] = 1'b0;
            head[d] = 0; tail[d] = 0;
        end
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s dut%0d (W=%0d S=%0d) cyc %0d: got %h want %h",
                      name, d, WS[d], ST[d], cyc, act, exp);
    endtask

    // Single compare process; each negedge looks at the transfers the next posedge will perform.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < ND; d++) begin
            exp_t e;
            if (rst_seen) begin
                chk("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
                chk("rst_s", d, s_a[d], 64'd0);
                chk("rst_cout", d, 64'(cout_a[d]), 64'd0);
                chk("rst_in_ready", d, 64'(in_ready[d]), 64'd1);
`ifdef PFA_PIPE_OVF_EN
                chk("rst_ovf", d, 64'(ovf_a[d]), 64'd0);
`endif
            end else if (prev_stall[d]) begin
                chk("hold_valid", d, 64'(out_valid[d]), 64'd1);
                chk("hold_s", d, s_a[d], prev_s[d]);
                chk("hold_cout", d, 64'(cout_a[d]), 64'(prev_c[d]));
`ifdef PFA_PIPE_OVF_EN
                chk("hold_ovf", d, 64'(ovf_a[d]), 64'(prev_o[d]));
`endif
            end
            chk("in_ready", d, 64'(in_ready[d]), 64'(!(out_valid[d] && !out_ready)));
            if (!rst_n) begin
                head[d] = 0;
                tail[d] = 0;
                prev_stall[d] = 1'b0;
            end else begin
                if (out_valid[d] && out_ready) begin
                    if (head[d] == tail[d]) begin
                        chk("stale_result", d, 64'(out_valid[d]), 64'd0);
                    end else begin
                        e = qbuf[d][head[d] % QD];
                        head[d]++;
                        chk("s", d, s_a[d], e.s);
                        chk("cout", d, 64'(cout_a[d]), 64'(e.c));
`ifdef PFA_PIPE_OVF_EN
                        chk("ovf", d, 64'(ovf_a[d]), 64'(e.o));
`endif
                        if (e.lit) begin
                            chk("lit_s", d, s_a[d], e.ls);
                            chk("lit_cout", d, 64'(cout_a[d]), 64'(e.lc));
`ifdef PFA_PIPE_OVF_EN
                            chk("lit_ovf", d, 64'(ovf_a[d]), 64'(e.lo));
`endif
                            chk("latency", d, 64'(cyc - e.cyc), 64'(ST[d]));
                        end
                    end
                end
                if (in_valid && in_ready[d]) begin
                    e     = model(WS[d], x, y, cin, sub);
                    e.lit = lit_en[d];
                    e.ls  = lit_s[d];
                    e.lc  = lit_c[d];
                    e.lo  = lit_o[d];
                    e.cyc = cyc;
                    qbuf[d][tail[d] % QD] = e;
                    tail[d]++;
                end
                prev_stall[d] = out_valid[d] && !out_ready;
            end
            prev_s[d] = s_a[d];
            prev_c[d] = cout_a[d];
            prev_o[d] = ovf_a[d];
            if (final_chk) chk("drained", d, 64'(tail[d] - head[d]), 64'd0);
        end
        rst_seen = !rst_n;
    end

    task automatic present(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb,
                           input int td, input logic [63:0] ls, input logic lc, input logic lo);
        lit_en[td] = 1'b1;
        lit_s[td]  = ls;
        lit_c[td]  = lc;
        lit_o[td]  = lo;
        x = a; y = b; cin = ci; sub = sb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lit_en[td] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        logic acc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        present(64'hFFFF, 64'h0001, 1'b0, 1'b0, 0, 64'h0000, 1'b1, 1'b0);
        present(64'd5, 64'd7, 1'b0, 1'b1, 1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        present(64'd7, 64'd5, 1'b0, 1'b1, 1, 64'd2, 1'b1, 1'b0);
        present(64'h7F, 64'h01, 1'b0, 1'b0, 2, 64'h80, 1'b0, 1'b1);
        present(64'h80, 64'hFF, 1'b0, 1'b0, 2, 64'h7F, 1'b1, 1'b1);
        present(64'h1FFF, 64'h0001, 1'b1, 1'b0, 3, 64'h0001, 1'b1, 1'b0);
        present(64'd1, 64'd1, 1'b0, 1'b0, 5, 64'd2, 1'b0, 1'b1);
        present(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4, 64'd0, 1'b1, 1'b0);

        // Backpressure: stream until the 2-stage 13-bit instance has taken 10 sets.
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 10; k++) begin
            x = 64'(k) * 64'h9E37_79B9_7F4A_7C15;
            y = 64'(k + 3) * 64'hC2B2_AE3D_27D4_EB4F;
            cin = k[0];
            sub = (k % 3) == 0;
            in_valid = 1'b1;
            out_ready = !(k >= 3 && k < 7);
            @(negedge clk);
            acc = in_ready[3];
            @(posedge clk); #1;
            if (acc) cnt++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Reset with operand sets still in flight.
        for (int k = 0; k < 3; k++) begin
            x = 64'(k + 11) * 64'h0123_4567_89AB_CDEF;
            y = 64'(k + 5) * 64'h0F0F_1234_5555_AAAA;
            cin = 1'b1; sub = k[0];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Random traffic with random bubbles and backpressure.
        for (int k = 0; k < 3000; k++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            cin = 1'($urandom);
            sub = 1'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 final_chk = 1'b1;
        @(posedge clk); #1;
        final_chk = 1'b0;
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
